// File: rtl/pipeline_stall_controller_pkg.sv
// rtl/pipeline_stall_controller_pkg.sv - shared types and default sizes for the stall controller
package pipeline_ctrl_pkg;

  localparam int REG_W_DEF    = 5;
  localparam int MAX_WAIT_DEF = 16;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// rtl/pipeline_stall_controller_if.sv - data-memory request/ready handshake
interface pipeline_stall_controller_if;

  logic mem_req;
  logic mem_ready;

  modport master (output mem_req, input mem_ready);
  modport slave  (input mem_req, output mem_ready);

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// rtl/pipeline_stall_controller_sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - load-use/branch/memory-wait stall and flush sequencer
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [REG_W-1:0]             Rs1D,
  input  logic [REG_W-1:0]             Rs2D,
  input  logic [REG_W-1:0]             RdE,
  input  logic                         MemReadE,
  input  logic                         PCSrcE,
  input  logic                         MemAccessM,
  pipeline_stall_controller_if.master  mem,
  output logic                         StallF,
  output logic                         StallD,
  output logic                         StallE,
  output logic                         StallM,
  output logic                         FlushD,
  output logic                         FlushE,
  output logic                         FlushW,
  output logic                         fault,
  output logic [CNT_W-1:0]             stall_cycles
);

  localparam int WCW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  ctrl_state_t    state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           mem_req_c;
  logic           lw_stall;
  logic           mem_hold;
  logic           pipe_rules;

  assign lw_stall = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_hold = MemAccessM && !mem.mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_req_c  = 1'b0;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;
    pipe_rules = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_hold) begin
          mem_req_c  = 1'b1;
          {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
          state_d    = WAIT;
          wait_cnt_d = WCW'(1);
        end else begin
          mem_req_c  = MemAccessM;
          pipe_rules = 1'b1;
        end
      end
      WAIT: begin
        mem_req_c = 1'b1;
        if (mem_hold) begin
          {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
          if (wait_cnt_q == WCW'(MAX_WAIT - 1)) begin
            state_d = FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
          end
        end else begin
          // ready (or a dropped access) releases the pipe this same cycle
          state_d    = RUN;
          wait_cnt_d = '0;
          pipe_rules = 1'b1;
        end
      end
      FAULT: begin
        {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (pipe_rules) begin
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end

    if (reset) begin
      mem_req_c = 1'b0;
      {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} = 7'b0;
    end
  end

  assign mem.mem_req = mem_req_c;
  assign fault       = (state_q == FAULT) && !reset;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallF),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed bench with a cycle-level reference model
module tb_pipeline_stall_controller;

  localparam int REG_W    = 5;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 3;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] Rs1D, Rs2D, RdE;
  logic             MemReadE, PCSrcE, MemAccessM;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW, fault;
  logic [CNT_W-1:0] stall_cycles;

  pipeline_stall_controller_if mif ();

  pipeline_stall_controller #(
    .REG_W(REG_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MemAccessM(MemAccessM),
    .mem(mif.master),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .fault(fault), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // reference model: is a memory access outstanding, how many stalled memory cycles so far, faulted?
  logic m_wait, m_fault;
  int   m_waited, m_count;

  // {mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  function automatic logic [7:0] model_out();
    logic [7:0] o;
    logic lw;
    lw = MemReadE && (RdE != 0) && ((RdE == Rs1D) || (RdE == Rs2D));
    o  = 8'b0;
    if (m_fault) o = 8'b0111_1001;
    else if (MemAccessM && !mif.mem_ready) o = 8'b1111_1001;
    else begin
      o[7] = MemAccessM || m_wait;
      if (PCSrcE) begin o[2] = 1'b1; o[1] = 1'b1; end
      else if (lw) begin o[6] = 1'b1; o[5] = 1'b1; o[1] = 1'b1; end
    end
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait <= 1'b0; m_fault <= 1'b0; m_waited <= 0; m_count <= 0;
    end else begin
      if (model_out() & 8'b0100_0000) m_count <= (m_count < SAT) ? m_count + 1 : SAT;
      if (!m_fault) begin
        if (MemAccessM && !mif.mem_ready) begin
          m_waited <= m_waited + 1;
          if (m_waited + 1 == MAX_WAIT) m_fault <= 1'b1;
          else m_wait <= 1'b1;
        end else begin
          m_wait <= 1'b0; m_waited <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_outputs",
            int'({mif.mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}),
            int'(model_out()));
      check("model_fault", int'(fault), int'(m_fault));
      check("model_stall_cycles", int'(stall_cycles), m_count);
    end
  end

  task automatic drive(input int rs1, input int rs2, input int rd, input bit mr,
                       input bit pc, input bit ma, input bit rdy);
    @(posedge clk); #1;
    Rs1D = REG_W'(rs1); Rs2D = REG_W'(rs2); RdE = REG_W'(rd);
    MemReadE = mr; PCSrcE = pc; MemAccessM = ma; mif.mem_ready = rdy;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    Rs1D = '0; Rs2D = '0; RdE = '0;
    MemReadE = 0; PCSrcE = 0; MemAccessM = 1; mif.mem_ready = 0;
    #12;
    check("reset_stallF", StallF, 0);
    check("reset_mem_req", mif.mem_req, 0);
    check("reset_flushW", FlushW, 0);
    check("reset_fault", fault, 0);
    check("reset_count", stall_cycles, 0);
    MemAccessM = 0;
    @(negedge clk); rst = 1'b0;

    drive(5, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    check("lu_stallF", StallF, 1);
    check("lu_stallD", StallD, 1);
    check("lu_flushE", FlushE, 1);
    check("lu_stallE", StallE, 0);

    drive(0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("lu_r0_stallF", StallF, 0);

    drive(3, 7, 7, 1, 1, 0, 0);
    @(negedge clk);
    check("br_flushD", FlushD, 1);
    check("br_flushE", FlushE, 1);
    check("br_stallF", StallF, 0);
    check("br_stallD", StallD, 0);

    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("mw_stallM", StallM, 1);
    check("mw_flushW", FlushW, 1);
    check("mw_mem_req", mif.mem_req, 1);
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      check("mw_hold_stallE", StallE, 1);
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    check("mw_rel_stallF", StallF, 0);
    check("mw_rel_stallM", StallM, 0);
    check("mw_rel_mem_req", mif.mem_req, 1);
    check("mw_count", stall_cycles, 3);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("mw_run_mem_req", mif.mem_req, 0);

    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    check("zw_mem_req", mif.mem_req, 1);
    check("zw_stallF", StallF, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("zw_mem_req_after", mif.mem_req, 0);
    check("zw_count", stall_cycles, 0);

    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("to_not_yet", fault, 0);
    @(posedge clk); @(negedge clk);
    check("to_fault", fault, 1);
    check("to_mem_req", mif.mem_req, 0);
    check("to_stallF", StallF, 1);
    check("to_flushW", FlushW, 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("sat_count", stall_cycles, SAT);
    drive(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("to_sticky", fault, 1);
    check("to_sticky_stallD", StallD, 1);

    #2 rst = 1'b1;
    #1;
    check("ar_stallF", StallF, 0);
    check("ar_flushW", FlushW, 0);
    check("ar_fault", fault, 0);
    check("ar_count", stall_cycles, 0);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("ar_run_stallF", StallF, 0);
    check("ar_run_fault", fault, 0);

    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline.
- Combines load-use hazard detection, taken-branch flushing and a wait-state handshake with the data memory.
- Drives per-stage stall/flush enables: F/D/E/M stall, D/E/W flush.
- A timeout watchdog on outstanding memory accesses forces a sticky fault. A saturating counter reports total front-end stall cycles.

Parameters:
REG_W, 5, register-specifier width
MAX_WAIT, 16, max memory wait cycles before fault (>=2)
CNT_W, 16, stall-cycle counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
Rs1D  input  REG_W  source reg 1 of instruction in D
Rs2D  input  REG_W  source reg 2 of instruction in D
RdE  input  REG_W  destination reg of instruction in E
MemReadE  input  1  instruction in E is a load
PCSrcE  input  1  taken branch/jump resolved in E
MemAccessM  input  1  instruction in M is a load or store
mem_ready  input  1  data memory completes the access this cycle
mem_req  output  1  request to data memory; held high until mem_ready
StallF, StallD, StallE, StallM  output  1 each  hold stage register (1 = hold)
FlushD, FlushE, FlushW  output  1 each  insert bubble into stage register
fault  output  1  sticky memory-timeout error
stall_cycles  output  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- While reset is high: state=RUN, wait_cnt=0, stall_cycles=0, fault=0. All stall/flush outputs and mem_req are 0.
- State machine (ctrl_state_t): RUN, WAIT, FAULT.
- lwStall = MemReadE & (RdE != 0) & ((RdE==Rs1D) | (RdE==Rs2D)).
- RUN, priority high to low:
  - MemAccessM & !mem_ready: mem_req=1; StallF/D/E/M=1; FlushW=1. Next state WAIT, wait_cnt<=1.
  - MemAccessM & mem_ready: mem_req=1, zero-wait completion. The rules below still apply this cycle.
  - PCSrcE: FlushD=1, FlushE=1, no stalls. Branch wins over a simultaneous lwStall.
  - lwStall: StallF=1, StallD=1, FlushE=1.
- WAIT:
  - mem_req=1; StallF/D/E/M=1; FlushW=1. lwStall and PCSrcE are ignored.
  - mem_ready=1: release. All stalls are 0 this cycle and the stage advances. Next RUN, wait_cnt<=0. Branch/load-use rules from RUN apply in this release cycle.
  - mem_ready=0 and wait_cnt==MAX_WAIT-1: next FAULT.
  - Otherwise: wait_cnt<=wait_cnt+1.
- FAULT: StallF/D/E/M=1, FlushW=1, mem_req=0, fault=1. Stays in FAULT until reset.
- MemAccessM dropping in WAIT (should not happen) is treated as completion: next RUN.
- All stall/flush/mem_req outputs are combinational from state and inputs. The state, wait_cnt, fault and stall_cycles registers change on clk rising edge.
- stall_cycles increments on each clk edge where StallF=1 (including FAULT). It saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-WAIT or in FAULT: outputs drop to 0 asynchronously. Next state is RUN.

Decomposition:
- Package pipeline_ctrl_pkg:
  - ctrl_state_t enum {RUN, WAIT, FAULT}
  - default constants for REG_W, MAX_WAIT, CNT_W
- Sub-module sat_counter (parameter W; ports clk, reset, inc, count). Used for stall_cycles.
- wait_cnt stays inline in the FSM.

Test Plan:
- Load-use: RdE=5, Rs1D=5, MemReadE=1, no memory access -> StallF=StallD=FlushE=1, StallE=0. Repeat with RdE=0 -> no stall.
- Branch vs load-use: PCSrcE=1 with lwStall true -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemAccessM=1, mem_ready low 3 cycles then high -> 3 cycles of StallF..M=1, FlushW=1, mem_req=1. Release cycle has stalls 0, then RUN. stall_cycles +3.
- Zero-wait: MemAccessM=1, mem_ready=1 same cycle -> mem_req=1, no stalls, state stays RUN.
- Timeout: MAX_WAIT=4, mem_ready held low -> FAULT entered after 4 WAIT-region cycles. fault=1 sticky, mem_req=0, stalls held. Async reset clears everything to 0 without a clock edge.
- Saturation: CNT_W=3, hold stall 10 cycles -> stall_cycles stops at 7.
